// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Bit positions inside the status byte returned on a STAT_ADDR read.
    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

    // Clocks per serial bit; integer divide, remainder is dropped.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory store/read path as seen by the UART: the CPU drives address,
// store data and MemWrite; the UART answers with a status byte and a hit flag.
interface mmio_uart_tx_if;
    logic [7:0] address;
    logic [7:0] data_in;
    logic       we;
    logic [7:0] rd_data;
    logic       hit;

    modport master (
        output address,
        output data_in,
        output we,
        input  rd_data,
        input  hit
    );

    modport slave (
        input  address,
        input  data_in,
        input  we,
        output rd_data,
        output hit
    );
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with a registered head. A push while full is ignored;
// push and pop may happen in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage and head register; a byte written into the slot that becomes the
    // head (FIFO empty after this cycle's pop) is bypassed straight to dout.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
        if (do_push && (wr_ptr == rd_ptr_nxt)) begin
            dout <= din;
        end else begin
            dout <= mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside the data RAM: stores to
// TX_ADDR queue bytes, a read of STAT_ADDR returns {overflow, full, busy}.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         BAUD       = 115200,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] TX_ADDR    = 8'hFF,
    parameter logic [7:0] STAT_ADDR  = 8'hFE
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           uart_txd,
    output logic           busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1;

    tx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               txd_d;
    logic               overflow_q;
    logic               bit_end;
    logic               pop;
    logic               push_req;
    logic               clr_req;
    logic [7:0]         fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;

    assign push_req = bus.we && (bus.address == TX_ADDR);
    assign clr_req  = bus.we && (bus.address == STAT_ADDR);
    assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: a store that finds the FIFO full is lost and flagged
    // until software writes the status address.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (clr_req) begin
            overflow_q <= 1'b0;
        end
    end

    // Transmit FSM state, baud counter, bit index and the registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            uart_txd <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            uart_txd <= txd_d;
        end
    end

    // Shift register holds only data, so it is left out of reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    // Next-state logic; the line value follows the state one clock later, and
    // the end of a stop bit pops the next byte directly to avoid an idle gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d = shreg_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE) || (fifo_count != '0);
    assign bus.hit = (bus.address == STAT_ADDR);

    // Status byte assembled from registered state.
    always_comb begin
        bus.rd_data            = '0;
        bus.rd_data[STAT_BUSY] = busy;
        bus.rd_data[STAT_FULL] = fifo_full;
        bus.rd_data[STAT_OVF]  = overflow_q;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios followed by randomized traffic,
// all checked every clock against a queue-and-timeline model of the transmitter.
module tb_mmio_uart_tx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic uart_txd;
    logic busy;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLK_HZ     (8),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH),
        .TX_ADDR    (8'hFF),
        .STAT_ADDR  (8'hFE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .uart_txd (uart_txd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: bytes waiting in the queue, the edge at which the byte
    // on the line was taken (-1 when idle) and the sticky overflow flag.
    int         edge_no   = 0;
    logic [7:0] q[$];
    int         cur_start = -1;
    logic [7:0] cur_byte  = 8'h00;
    logic       ovf_m     = 1'b0;

    // Line level after edge edge_no: the frame occupies the 10 bit slots that
    // begin one edge after the byte was taken.
    function automatic logic exp_txd();
        int k;
        if (cur_start < 0 || edge_no < cur_start + 1 || edge_no > cur_start + FRAME)
            return 1'b1;
        k = (edge_no - cur_start - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur_byte[k-1];
    endfunction

    function automatic logic exp_busy();
        return (cur_start >= 0) || (q.size() > 0);
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] a, input logic [7:0] d, input logic w);
        int pre_n;
        if (r) begin
            q.delete();
            cur_start = -1;
            ovf_m     = 1'b0;
            return;
        end
        pre_n = q.size();
        // Transmitter is free when idle or on the edge its current frame ends.
        if (cur_start < 0 || edge_no == cur_start + FRAME) begin
            if (pre_n > 0) begin
                cur_byte  = q.pop_front();
                cur_start = edge_no;
            end else begin
                cur_start = -1;
            end
        end
        if (w && a == 8'hFF) begin
            if (pre_n == DEPTH) ovf_m = 1'b1;
            else q.push_back(d);
        end
        if (w && a == 8'hFE) ovf_m = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s at edge %0d: observed=%02h expected=%02h", tag, edge_no, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic [7:0] a, input logic [7:0] d, input logic w);
        logic [7:0] exp_stat;
        rst         = r;
        bus.address = a;
        bus.data_in = d;
        bus.we      = w;
        @(posedge clk);
        edge_no++;
        model_edge(r, a, d, w);
        #1;
        exp_stat = {5'b0, ovf_m, (q.size() == DEPTH), exp_busy()};
        check("txd",     {7'b0, uart_txd}, {7'b0, exp_txd()});
        check("busy",    {7'b0, busy},     {7'b0, exp_busy()});
        check("rd_data", bus.rd_data,      exp_stat);
        check("hit",     {7'b0, bus.hit},  {7'b0, (a == 8'hFE)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        int rate;
        int sel;
        logic [7:0] addr;
        logic r;
        logic w;

        // Reset with the status address selected.
        tick(1'b1, 8'hFE, 8'h00, 1'b0);
        tick(1'b1, 8'hFE, 8'h00, 1'b0);
        tick(1'b0, 8'hFE, 8'h00, 1'b0);
        check("t1_txd",  {7'b0, uart_txd}, 8'h01);
        check("t1_busy", {7'b0, busy},     8'h00);
        check("t1_hit",  {7'b0, bus.hit},  8'h01);
        check("t1_rd",   bus.rd_data,      8'h00);

        // Single byte A5: start bit two edges after the store, idle by N+82.
        tick(1'b0, 8'hFF, 8'hA5, 1'b1);
        idle(2);
        check("t2_start", {7'b0, uart_txd}, 8'h00);
        idle(78);
        check("t2_busy_hi", {7'b0, busy}, 8'h01);
        idle(2);
        check("t2_busy_lo", {7'b0, busy}, 8'h00);
        idle(4);

        // Six back-to-back stores: the sixth is dropped and flags overflow.
        for (int i = 1; i <= 6; i++) tick(1'b0, 8'hFF, 8'(i), 1'b1);
        check("t3_status", bus.rd_data, 8'h07);
        // Store to the status address clears overflow while still sending.
        tick(1'b0, 8'hFE, 8'h5A, 1'b1);
        check("t4_status", bus.rd_data, 8'h03);
        idle(5 * FRAME + 10);
        check("t3_drained", {7'b0, busy}, 8'h00);

        // Reset 30 clocks into a frame with two bytes still queued.
        tick(1'b0, 8'hFF, 8'h11, 1'b1);
        tick(1'b0, 8'hFF, 8'h22, 1'b1);
        tick(1'b0, 8'hFF, 8'h33, 1'b1);
        idle(29);
        tick(1'b1, 8'h00, 8'h00, 1'b0);
        check("t5_txd",  {7'b0, uart_txd}, 8'h01);
        check("t5_busy", {7'b0, busy},     8'h00);
        idle(2 * FRAME);
        check("t5_quiet", {7'b0, busy}, 8'h00);

        // Store to an unrelated address is ignored.
        tick(1'b0, 8'h10, 8'h3C, 1'b1);
        check("t6_hit", {7'b0, bus.hit}, 8'h00);
        idle(20);
        check("t6_busy", {7'b0, busy}, 8'h00);

        // Randomized traffic in segments of differing store density.
        for (int seg = 0; seg < 5; seg++) begin
            case (seg)
                0: rate = 2;
                1: rate = 20;
                2: rate = 4;
                3: rate = 50;
                default: rate = 3;
            endcase
            for (int i = 0; i < 600; i++) begin
                r   = ($urandom_range(0, 799) == 0);
                w   = ($urandom_range(0, 99) < rate);
                sel = $urandom_range(0, 9);
                if (sel < 6)      addr = 8'hFF;
                else if (sel < 8) addr = 8'hFE;
                else              addr = 8'($urandom_range(0, 255));
                tick(r, addr, 8'($urandom_range(0, 255)), w);
            end
        end
        idle(DEPTH * FRAME + FRAME + 10);
        check("final_idle", {7'b0, busy}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
